// File: rtl/oled_spi_rx_if.sv
// Receive-side consumer handshake for oled_spi_rx: FIFO head data, dc_n tag, valid/ready.
interface oled_spi_rx_if;
  logic [7:0] o_rx_data;
  logic       o_rx_dc_n;
  logic       o_rx_valid;
  logic       i_rx_ready;

  modport master (output o_rx_data, output o_rx_dc_n, output o_rx_valid, input  i_rx_ready);
  modport slave  (input  o_rx_data, input  o_rx_dc_n, input  o_rx_valid, output i_rx_ready);
endinterface

// File: rtl/oled_spi_rx.sv
// Snoops the OLED SPI bus (mode 3, MSB first), deserializes bytes tagged with dc_n
// into a first-word-fall-through FIFO, and keeps sticky error flags plus a data-byte count.
module oled_spi_rx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int FIFO_DEPTH   = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  input  logic          i_oled_sclk,
  input  logic          i_oled_sdin,
  input  logic          i_oled_dc_n,
  input  logic          i_oled_rst_n,
  input  logic          i_clear_flags,
  oled_spi_rx_if.master rx,
  output logic          o_overflow,
  output logic          o_frame_err,
  output logic [15:0]   o_byte_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  logic unused_clk_freq;
  assign unused_clk_freq = ^CLK_FREQ;

  // Bit order in both stages: {sclk, sdin, dc_n, rst_n}
  logic [3:0] sync1, sync2;
  logic       sclk_s, sdin_s, dc_s, disp_s;
  logic       sclk_q, disp_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      sclk_q <= 1'b0;
      disp_q <= 1'b0;
    end else begin
      sync1  <= {i_oled_sclk, i_oled_sdin, i_oled_dc_n, i_oled_rst_n};
      sync2  <= sync1;
      sclk_q <= sclk_s;
      disp_q <= disp_s;
    end
  end

  assign {sclk_s, sdin_s, dc_s, disp_s} = sync2;

  // Requiring display reset inactive for two consecutive samples masks the 0->1 step
  // of the synchronized idle-high SCLK right after i_arst_n release.
  logic disp_run, sclk_rise;
  assign disp_run  = disp_s & disp_q;
  assign sclk_rise = sclk_s & ~sclk_q & disp_run;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  logic [2:0]     bit_cnt;
  logic [6:0]     shreg;
  logic [TW-1:0]  idle_cnt;
  logic           timeout;
  logic           wr_en;
  logic [8:0]     wr_entry;

  assign timeout  = disp_run && (state == SHIFT) && !sclk_rise && (idle_cnt == TW'(IDLE_TIMEOUT - 1));
  assign wr_en    = sclk_rise && (state == SHIFT) && (bit_cnt == 3'd7);
  assign wr_entry = {dc_s, shreg, sdin_s};

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      idle_cnt <= '0;
    end else if (!disp_run) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else if (sclk_rise) begin
      shreg    <= {shreg[5:0], sdin_s};
      idle_cnt <= '0;
      if (state == SHIFT && bit_cnt == 3'd7) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end else begin
        state   <= SHIFT;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end else if (state == SHIFT) begin
      if (timeout) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end
    end
  end

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] fill;
  logic          valid, full, pop, push_ok, drop;
  logic [8:0]    head;

  assign valid   = (fill != '0);
  assign full    = (fill == CW'(FIFO_DEPTH));
  assign pop     = valid & rx.i_rx_ready;
  // A pop on the same edge frees the slot, so a write into a full FIFO still lands.
  assign push_ok = wr_en & (~full | pop);
  assign drop    = wr_en & full & ~pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fill <= fill + CW'(1);
        2'b01:   fill <= fill - CW'(1);
        default: fill <= fill;
      endcase
    end
  end

  assign rx.o_rx_valid = valid;
  assign rx.o_rx_data  = valid ? head[7:0] : '0;
  assign rx.o_rx_dc_n  = valid ? head[8]   : 1'b0;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_overflow   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_byte_count <= '0;
    end else begin
      o_overflow  <= drop    | (o_overflow  & ~i_clear_flags);
      o_frame_err <= timeout | (o_frame_err & ~i_clear_flags);
      if (push_ok && wr_entry[8]) o_byte_count <= o_byte_count + 16'd1;
    end
  end

endmodule
